// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// datapath mux selects, ALU operation classes and trap causes.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_LUI       = 4'd4,
    S_AUIPC     = 4'd5,
    S_ALU_WB    = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_LOAD  = 4'd8,
    S_LOAD_WB   = 4'd9,
    S_MEM_STORE = 4'd10,
    S_BRANCH    = 4'd11,
    S_JAL       = 4'd12,
    S_JALR      = 4'd13,
    S_TRAP      = 4'd14
  } state_t;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_BRANCH  = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;
  localparam logic [1:0] ALU_PASS_B  = 2'b11;

  localparam logic [1:0] M2R_ALUOUT  = 2'b00;
  localparam logic [1:0] M2R_MDR     = 2'b01;
  localparam logic [1:0] M2R_PC      = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_LOAD) || (s == S_MEM_STORE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles of one memory access and flags the cycle
// in which the stall reaches MEM_TIMEOUT (never, when MEM_TIMEOUT is 0).
module mem_wait_timer #(
  parameter int WAIT_W      = 8,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT);

  logic [WAIT_W-1:0] r_count;

  // Every wait state is left only on ready or into TRAP, so clearing on
  // !active or ready also covers every state change.
  always_ff @(posedge clk) begin
    if (rst || !active || ready) r_count <= '0;
    else                         r_count <= r_count + WAIT_W'(1);
  end

  assign expired = (MEM_TIMEOUT != 0) && active && !ready && (r_count == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I main control FSM with memory-wait timeout, illegal-opcode
// trap and cycle/instret counters.
module multicycle_control_unit
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int WAIT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_src,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             retire,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output state_t           dbg_state
);

  state_t           r_state, w_next_state;
  logic [1:0]       r_trap_cause, w_next_cause;
  logic [CNT_W-1:0] r_cycle_cnt, r_instret_cnt;
  logic             w_expired;

  mem_wait_timer #(.WAIT_W(WAIT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (is_wait_state(r_state)),
    .ready   (mem_ready),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_trap_cause  <= CAUSE_NONE;
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_state      <= w_next_state;
      r_trap_cause <= w_next_cause;
      r_cycle_cnt  <= r_cycle_cnt + CNT_W'(1);
      if (retire) r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  // Memory handshake: mem_read/mem_write is a request held steady every cycle
  // of the access; the access completes in the cycle mem_ready is 1.
  always_comb begin
    w_next_state  = r_state;
    w_next_cause  = r_trap_cause;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_ADD;
    mem_to_reg    = M2R_ALUOUT;
    reg_write     = 1'b0;
    retire        = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_expired) begin
          w_next_state = S_TRAP;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_R:                w_next_state = S_EXEC_R;
          OP_IMM:              w_next_state = S_EXEC_I;
          OP_LOAD, OP_STORE:   w_next_state = S_MEM_ADDR;
          OP_BRANCH:           w_next_state = S_BRANCH;
          OP_JAL:              w_next_state = S_JAL;
          OP_JALR:             w_next_state = S_JALR;
          OP_LUI:              w_next_state = S_LUI;
          OP_AUIPC:            w_next_state = S_AUIPC;
          default: begin
            w_next_state = S_TRAP;
            w_next_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1; alu_op = ALU_FUNCT; w_next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1; alu_src_b = SRC_B_IMM; alu_op = ALU_FUNCT;
        w_next_state = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_b = SRC_B_IMM; alu_op = ALU_PASS_B; w_next_state = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a = SRC_A_OLDPC; alu_src_b = SRC_B_IMM; w_next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1; retire = 1'b1; w_next_state = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1; alu_src_b = SRC_B_IMM;
        w_next_state = opcode[5] ? S_MEM_STORE : S_MEM_LOAD;
      end
      S_MEM_LOAD: begin
        mem_read = 1'b1; i_or_d = 1'b1;
        if (mem_ready) w_next_state = S_LOAD_WB;
        else if (w_expired) begin
          w_next_state = S_TRAP;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end
      S_LOAD_WB: begin
        reg_write = 1'b1; mem_to_reg = M2R_MDR; retire = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEM_STORE: begin
        mem_write = 1'b1; i_or_d = 1'b1;
        if (mem_ready) begin
          retire       = 1'b1;
          w_next_state = S_FETCH;
        end else if (w_expired) begin
          w_next_state = S_TRAP;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1; alu_op = ALU_BRANCH; pc_write_cond = 1'b1;
        pc_src = 1'b1; retire = 1'b1; w_next_state = S_FETCH;
      end
      S_JAL: begin
        reg_write = 1'b1; mem_to_reg = M2R_PC; pc_write = 1'b1; pc_src = 1'b1;
        retire = 1'b1; w_next_state = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = SRC_A_RS1; alu_src_b = SRC_B_IMM; reg_write = 1'b1;
        mem_to_reg = M2R_PC; pc_write = 1'b1; retire = 1'b1;
        w_next_state = S_FETCH;
      end
      default: w_next_state = S_TRAP;
    endcase
    // Reset silences every enable and request, even mid-access.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      retire        = 1'b0;
    end
  end

  assign trap        = (r_state == S_TRAP);
  assign trap_cause  = r_trap_cause;
  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected control vectors
// are built from the instruction-class rules and checked every cycle.
module tb_multicycle_control_unit;
  import riscv_pkg::*;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          mem_ready;
  logic          pc_write, pc_write_cond, pc_src, ir_write, i_or_d;
  logic          mem_read, mem_write, reg_write, retire, trap;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, mem_to_reg, trap_cause;
  logic [CW-1:0] cycle_cnt, instret_cnt;
  state_t        dbg_state;

  multicycle_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .retire(retire), .trap(trap), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int inst  = 0;
  logic [1:0]  exp_cause = 2'b00;
  logic [18:0] exp_q[$];
  bit          rdy_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  // {pw,pwc,psrc,irw,iord,mr,mw,src_a,src_b,alu_op,m2r,rw,retire,trap}
  function automatic logic [18:0] ctl(input bit pw, pwc, psrc, irw, iord, mr, mw,
                                     input logic [1:0] sa, sb, op, m2r,
                                     input bit rw, ret, trp);
    return {pw, pwc, psrc, irw, iord, mr, mw, sa, sb, op, m2r, rw, ret, trp};
  endfunction

  function automatic logic [18:0] obs();
    return {pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read, mem_write,
            alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write, retire, trap};
  endfunction

  localparam logic [18:0] EN_MASK = 19'b1101011_00000000_110;

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  // driver tasks
  task automatic push(input logic [18:0] v, input bit r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endtask

  task automatic push_fetch(input int w);
    repeat (w) push(ctl(0,0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b00,0,0,0), 1'b0);
    push(ctl(1,0,0,1,0,1,0,2'b00,2'b10,2'b00,2'b00,0,0,0), 1'b1);
  endtask

  task automatic push_trap(input int n);
    repeat (n) push(ctl(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,1), rnd());
  endtask

  task automatic queue_instr(input logic [6:0] op, input int wf, input int wm);
    logic [18:0] alu_wb, mem_addr, ld, st;
    alu_wb   = ctl(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0);
    mem_addr = ctl(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0,0);
    ld       = ctl(0,0,0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
    st       = ctl(0,0,0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,0,0,0);
    push_fetch(wf);
    push(ctl(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0,0), rnd());
    case (op)
      OP_R:   begin push(ctl(0,0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0,0), rnd()); push(alu_wb, rnd()); end
      OP_IMM: begin push(ctl(0,0,0,0,0,0,0,2'b10,2'b01,2'b10,2'b00,0,0,0), rnd()); push(alu_wb, rnd()); end
      OP_LUI: begin push(ctl(0,0,0,0,0,0,0,2'b00,2'b01,2'b11,2'b00,0,0,0), rnd()); push(alu_wb, rnd()); end
      OP_AUIPC: begin push(ctl(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0,0), rnd()); push(alu_wb, rnd()); end
      OP_LOAD: begin
        push(mem_addr, rnd());
        repeat (wm) push(ld, 1'b0);
        push(ld, 1'b1);
        push(ctl(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b01,1,1,0), rnd());
      end
      OP_STORE: begin
        push(mem_addr, rnd());
        repeat (wm) push(st, 1'b0);
        push(st | 19'd2, 1'b1);
      end
      OP_BRANCH: push(ctl(0,1,1,0,0,0,0,2'b10,2'b00,2'b01,2'b00,0,1,0), rnd());
      OP_JAL:    push(ctl(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b10,1,1,0), rnd());
      OP_JALR:   push(ctl(1,0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b10,1,1,0), rnd());
      default:   push_trap(20);
    endcase
  endtask

  // scoreboard: one expected vector per clock cycle
  task automatic run_q();
    logic [18:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
      #2;
      check("ctl", 32'(obs()), 32'(e));
      check("cycle_cnt", 32'(cycle_cnt), 32'(cyc % (1 << CW)));
      check("instret_cnt", 32'(instret_cnt), 32'(inst % (1 << CW)));
      check("trap_cause", 32'(trap_cause), e[0] ? 32'(exp_cause) : 32'(0));
      @(posedge clk);
      #1;
      cyc++;
      if (e[1]) inst++;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      mem_ready = rnd();
      #2;
      check("rst_enables", 32'(obs() & EN_MASK), 32'(0));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    cyc = 0;
    inst = 0;
    exp_cause = CAUSE_NONE;
    #1;
    check("rst_state", 32'(dbg_state), 32'(S_FETCH));
    check("rst_trap", 32'(trap), 32'(0));
  endtask

  logic [6:0] legal_ops[9];

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic instr(input logic [6:0] op, input int wf, input int wm);
    opcode = op;
    if (!is_legal(op)) exp_cause = CAUSE_ILLEGAL;
    queue_instr(op, wf, wm);
    run_q();
  endtask

  initial begin
    legal_ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    rst = 1'b1;
    opcode = OP_IMM;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // directed: addi, lw with 3 waits, beq, jal
    instr(OP_IMM, 0, 0);
    check("addi_cycles", 32'(cycle_cnt), 32'(4));
    check("addi_instret", 32'(instret_cnt), 32'(1));
    instr(OP_LOAD, 0, 3);
    instr(OP_BRANCH, 0, 0);
    instr(OP_JAL, 0, 0);

    // illegal opcode: absorbing trap, counters keep ticking
    instr(7'b1111111, 0, 0);
    do_reset(2);

    // fetch timeout after the TO+1-th stalled cycle
    opcode = OP_R;
    exp_cause = CAUSE_TIMEOUT;
    repeat (TO + 1) push(ctl(0,0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b00,0,0,0), 1'b0);
    push_trap(6);
    run_q();
    do_reset(1);

    // ready on exactly the last allowed cycle wins over the timeout
    instr(OP_IMM, TO, 0);
    instr(OP_STORE, 1, TO);

    // reset in the middle of a stalled store
    opcode = OP_STORE;
    queue_instr(OP_STORE, 0, 0);
    void'(exp_q.pop_back());
    void'(rdy_q.pop_back());
    push(ctl(0,0,0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,0,0,0), 1'b0);
    run_q();
    do_reset(1);
    instr(OP_LUI, 0, 0);

    // randomized mix including timeouts in every wait state
    for (int i = 0; i < 150; i++) begin
      int sel;
      logic [6:0] op;
      sel = int'($urandom_range(0, 99));
      if (sel < 5) begin
        do op = 7'($urandom); while (is_legal(op));
        instr(op, int'($urandom_range(0, TO)), 0);
        do_reset(int'($urandom_range(1, 2)));
      end else if (sel < 10) begin
        op = ($urandom_range(0, 1) == 0) ? OP_LOAD : OP_STORE;
        opcode = op;
        exp_cause = CAUSE_TIMEOUT;
        if (sel < 7) begin
          repeat (TO + 1) push(ctl(0,0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b00,0,0,0), 1'b0);
        end else begin
          push_fetch(int'($urandom_range(0, TO)));
          push(ctl(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0,0), rnd());
          push(ctl(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0,0), rnd());
          repeat (TO + 1)
            push(ctl(0,0,0,0,1,op == OP_LOAD,op == OP_STORE,2'b00,2'b00,2'b00,2'b00,0,0,0), 1'b0);
        end
        push_trap(3);
        run_q();
        do_reset(1);
      end else begin
        op = legal_ops[$urandom_range(0, 8)];
        instr(op, int'($urandom_range(0, TO)), int'($urandom_range(0, TO)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
